// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment search over 10 bit phases, control-token
// lock/loss tracking, and 10b->8b data decode with a two-stage output pipeline.
module tmds_channel_decoder #(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int LOSS_TIMEOUT   = 2048
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] din,
    output logic [7:0] dout,
    output logic       de,
    output logic       c0,
    output logic       c1,
    output logic       locked,
    output logic       lock_lost,
    output logic [3:0] offset
);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_COUNT - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TIMEOUT - 1);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    // returns {is_token, c1, c0}
    function automatic logic [2:0] classify(input logic [9:0] w);
        case (w)
            10'b1101010100: classify = 3'b100;
            10'b0010101011: classify = 3'b101;
            10'b0101010100: classify = 3'b110;
            10'b1010101011: classify = 3'b111;
            default:        classify = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] o;
        d    = w[9] ? ~w[7:0] : w[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++)
            o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    state_t          state, state_nxt;
    logic [9:0]      prev, s1, aligned;
    logic [19:0]     word20;
    logic [RW-1:0]   run_cnt, run_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic [LW-1:0]   loss_cnt, loss_nxt;
    logic [3:0]      off_nxt;
    logic            settle, settle_nxt, lost_nxt;
    logic [2:0]      s1_cls;
    logic            s1_tok;
    logic [7:0]      dout_r;
    logic            de_r, c0_r, c1_r;

    assign word20  = {din, prev};
    assign aligned = 10'(word20 >> offset);
    assign s1_cls  = classify(s1);
    assign s1_tok  = s1_cls[2];

    always_comb begin
        state_nxt  = state;
        run_nxt    = run_cnt;
        tmr_nxt    = tmr;
        loss_nxt   = loss_cnt;
        off_nxt    = offset;
        settle_nxt = 1'b0;
        lost_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                tmr_nxt = tmr + 1'b1;
                // the word right after an offset change was captured at the old offset
                if (!settle)
                    run_nxt = s1_tok ? run_cnt + 1'b1 : '0;
                if (!settle && s1_tok && run_cnt == RUN_LAST) begin
                    state_nxt = LOCKED;
                    run_nxt   = '0;
                    tmr_nxt   = '0;
                    loss_nxt  = '0;
                end else if (tmr == TMR_LAST) begin
                    off_nxt    = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                    tmr_nxt    = '0;
                    run_nxt    = '0;
                    settle_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (s1_tok) begin
                    loss_nxt = '0;
                end else if (loss_cnt == LOSS_LAST) begin
                    state_nxt = SEARCH;
                    lost_nxt  = 1'b1;
                    loss_nxt  = '0;
                    run_nxt   = '0;
                    tmr_nxt   = '0;
                end else begin
                    loss_nxt = loss_cnt + 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= SEARCH;
            prev      <= '0;
            s1        <= '0;
            offset    <= '0;
            run_cnt   <= '0;
            tmr       <= '0;
            loss_cnt  <= '0;
            settle    <= 1'b0;
            lock_lost <= 1'b0;
            dout_r    <= '0;
            de_r      <= 1'b0;
            c0_r      <= 1'b0;
            c1_r      <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= din;
            s1        <= aligned;
            offset    <= off_nxt;
            run_cnt   <= run_nxt;
            tmr       <= tmr_nxt;
            loss_cnt  <= loss_nxt;
            settle    <= settle_nxt;
            lock_lost <= lost_nxt;
            dout_r    <= s1_tok ? 8'h00 : decode(s1);
            de_r      <= ~s1_tok;
            c1_r      <= s1_tok & s1_cls[1];
            c0_r      <= s1_tok & s1_cls[0];
        end
    end

    // gating on the state register keeps outputs quiet the instant lock drops
    assign locked = (state == LOCKED);
    assign dout   = locked ? dout_r : 8'h00;
    assign de     = locked & de_r;
    assign c0     = locked & c0_r;
    assign c1     = locked & c1_r;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboarded bench for tmds_channel_decoder: reset, lock-priority boundary,
// phase-3 alignment, data/control decode, and loss of lock.
module tb_tmds_channel_decoder;
    localparam int LC    = 4;
    localparam int ST    = 64;
    localparam int LT    = 300;
    localparam int BOUND = 3 * ST + LC + 4;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] din = '0;
    logic [7:0] dout;
    logic       de, c0, c1, locked, lock_lost;
    logic [3:0] offset;

    tmds_channel_decoder #(.LOCK_COUNT(LC), .SEARCH_TIMEOUT(ST), .LOSS_TIMEOUT(LT)) dut (
        .clk(clk), .resetn(resetn), .din(din), .dout(dout), .de(de), .c0(c0), .c1(c1),
        .locked(locked), .lock_lost(lock_lost), .offset(offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] val;   // {de, c1, c0, dout}
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          enc_cnt = 0;
    logic        sb_on = 1'b0;
    logic [9:0]  last_sym = T00;
    logic [10:0] last_exp = 11'h000;

    always @(posedge clk or negedge resetn)
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // standard DVI encoder with running disparity, used only to build stimulus
    function automatic logic [9:0] tmds_enc(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        logic       use_xnor;
        int         n1, n0;
        use_xnor = ($countones(d) > 4) || ($countones(d) == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~use_xnor;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (enc_cnt == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            enc_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((enc_cnt > 0 && n1 > n0) || (enc_cnt < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt += 2 * int'(qm[8]) + n0 - n1;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt += -2 * int'(!qm[8]) + n1 - n0;
        end
        return q;
    endfunction

    // stream delayed by 3 bits: each din word finishes the previous symbol
    task automatic send_p3(input logic [9:0] sym, input logic [10:0] ex);
        exp_t e;
        din = {sym[6:0], last_sym[9:7]};
        if (sb_on) begin
            e.val = last_exp;
            e.due = cyc + 2;
            q.push_back(e);
        end
        last_sym = sym;
        last_exp = ex;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("sb_due", cyc, e.due);
                chk("sb_out", {de, c1, c0, dout}, e.val);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [9:0] bd_word(input int k);
        return (k <= ST - 2 - LC) ? tmds_enc(8'(k)) : T00;
    endfunction

    initial begin : stim
        int pulses;
        // reset with random input
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            din = 10'($urandom);
        end
        chk("rst_locked", locked, 0);
        chk("rst_de", de, 0);
        chk("rst_dout", dout, 0);
        chk("rst_c", {c1, c0}, 0);
        chk("rst_offset", offset, 0);
        chk("rst_lost", lock_lost, 0);

        // boundary: LC-th token reaches stage 1 on the search timer expiry edge
        @(negedge clk);
        resetn = 1'b1;
        din = bd_word(1);
        for (int k = 2; k <= ST + 4; k++) begin
            @(negedge clk);
            if (cyc == ST - 1) chk("bnd_prelock", locked, 0);
            if (cyc == ST) begin
                chk("bnd_locked", locked, 1);
                chk("bnd_offset", offset, 0);
            end
            din = bd_word(k);
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            din = tmds_enc(8'hA5);
        end
        @(negedge clk);
        chk("bnd_de", de, 1);
        chk("bnd_dout", dout, 8'hA5);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_de", de, 0);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_c", {c1, c0}, 0);
        chk("mid_rst_offset", offset, 0);
        chk("mid_rst_lost", lock_lost, 0);
        repeat (3) @(negedge clk);

        // alignment on a phase-3 token stream
        enc_cnt = 0;
        last_sym = T00;
        last_exp = 11'h000;
        resetn = 1'b1;
        send_p3(T00, 11'h000);
        for (int k = 0; k < BOUND + 2; k++) begin
            @(negedge clk);
            if (cyc == ST - 1)     chk("align_off0", offset, 0);
            if (cyc == ST)         chk("align_off1", offset, 1);
            if (cyc == 2 * ST)     chk("align_off2", offset, 2);
            if (cyc == 3 * ST)     chk("align_off3", offset, 3);
            if (locked) break;
            send_p3(T00, 11'h000);
        end
        chk("align_locked", locked, 1);
        chk("align_offset", offset, 3);
        chk("align_in_time", (cyc <= BOUND), 1);

        // data bytes then the four control tokens
        sb_on = 1'b1;
        for (int b = 0; b < 256; b++) begin
            @(negedge clk);
            send_p3(tmds_enc(8'(b)), {3'b100, 8'(b)});
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk); send_p3(T00, 11'b000_00000000);
            @(negedge clk); send_p3(T01, 11'b001_00000000);
            @(negedge clk); send_p3(T10, 11'b010_00000000);
            @(negedge clk); send_p3(T11, 11'b011_00000000);
        end
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); send_p3(T00, 11'b000_00000000);
        end
        sb_on = 1'b0;
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        chk("sb_drained", q.size(), 0);

        // loss of lock on a long data run
        pulses = 0;
        for (int k = 0; k < LT + 20; k++) begin
            @(negedge clk);
            if (lock_lost) pulses++;
            if (k == 10) chk("loss_still_locked", locked, 1);
            if (pulses > 0 && !lock_lost) break;
            send_p3(tmds_enc(8'h3C + 8'(k)), 11'h000);
        end
        chk("loss_pulse_width", pulses, 1);
        chk("loss_locked", locked, 0);
        chk("loss_offset", offset, 3);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("loss_de", de, 0);
            chk("loss_dout", dout, 0);
            send_p3(tmds_enc(8'h77), 11'h000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
